// File: rtl/mem_lsu_if.sv
// RAM bus between the MEM-stage load/store unit and a wait-stated memory.
// Word-addressed requests with byte-lane enables and a single-cycle ack.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              ram_ce;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ack;

  modport master (
    output ram_ce, ram_we, ram_be, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_ce, ram_we, ram_be, ram_addr, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/mem_lsu.sv
// MIPS MEM-stage load/store unit: byte/half/word accesses over a wait-stated bus,
// load extension, misalignment and bus-timeout exceptions, one result per op.
module mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              wreg_en_i,
  input  logic [REG_AW-1:0] wreg_addr_i,
  output logic              out_valid,
  output logic              wreg_en_o,
  output logic [REG_AW-1:0] wreg_addr_o,
  output logic [31:0]       wreg_data_o,
  output logic              stall_req,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic [ADDR_W-1:0] bad_addr,
  mem_lsu_if.master         bus
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    logic half, word;
    half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word = (op == OP_LW) || (op == OP_SW);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: return 4'b0011 << a;
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] w);
    case (op)
      OP_SB:   return {4{w[7:0]}};
      OP_SH:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    lane = rdata >> {a, 3'b000};
    b    = lane[7:0];
    h    = a[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  state_t state, state_n;

  // Operation latched at accept, held stable for the whole bus access
  logic [3:0]        op_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wdata_p0;
  logic              wreg_en_p0;
  logic [7:0]        cnt_p0;

  // Writeback result presented during DONE
  logic              res_en_p1;
  logic [REG_AW-1:0] res_addr_p1;
  logic [31:0]       res_data_p1;
  logic              exc_p1;
  logic [1:0]        exc_code_p1;
  logic [ADDR_W-1:0] bad_addr_p1;

  logic mem_op_i, mis_i, tmo, bus_act;

  assign mem_op_i = is_load(op_i) || is_store(op_i);
  assign mis_i    = mem_op_i && misaligned(op_i, addr_i[1:0]);
  assign tmo      = (cnt_p0 == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    stall_req = 1'b0;
    bus_act   = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (mem_op_i && !mis_i) ? BUS : DONE;
      end
      BUS: begin
        stall_req = 1'b1;
        bus_act   = 1'b1;
        if (bus.ram_ack || tmo) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_p0       <= '0;
      addr_p0     <= '0;
      be_p0       <= '0;
      wdata_p0    <= '0;
      wreg_en_p0  <= 1'b0;
      cnt_p0      <= '0;
      res_en_p1   <= 1'b0;
      res_addr_p1 <= '0;
      res_data_p1 <= '0;
      exc_p1      <= 1'b0;
      exc_code_p1 <= '0;
      bad_addr_p1 <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_p0       <= op_i;
          addr_p0     <= addr_i;
          be_p0       <= byte_en(op_i, addr_i[1:0]);
          wdata_p0    <= store_lanes(op_i, wdata_i);
          wreg_en_p0  <= wreg_en_i;
          cnt_p0      <= '0;
          res_addr_p1 <= wreg_addr_i;
          res_data_p1 <= wdata_i;
          res_en_p1   <= wreg_en_i && !mis_i;
          exc_p1      <= mis_i;
          exc_code_p1 <= is_store(op_i) ? EXC_ADES : EXC_ADEL;
          bad_addr_p1 <= addr_i;
        end
        // Ack beats the timeout when both land in the same cycle
        BUS: begin
          if (bus.ram_ack) begin
            res_data_p1 <= load_extend(op_p0, addr_p0[1:0], bus.ram_rdata);
            res_en_p1   <= is_load(op_p0) && wreg_en_p0;
            exc_p1      <= 1'b0;
          end else if (tmo) begin
            res_en_p1   <= 1'b0;
            exc_p1      <= 1'b1;
            exc_code_p1 <= EXC_BUS;
            bad_addr_p1 <= addr_p0;
          end else begin
            cnt_p0 <= cnt_p0 + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wreg_en_o   = res_en_p1;
  assign wreg_addr_o = res_addr_p1;
  assign wreg_data_o = res_data_p1;
  assign exc_valid   = out_valid && exc_p1;
  assign exc_code    = exc_code_p1;
  assign bad_addr    = bad_addr_p1;

  assign bus.ram_ce    = bus_act;
  assign bus.ram_we    = bus_act && is_store(op_p0);
  assign bus.ram_be    = bus_act ? be_p0 : 4'b0000;
  assign bus.ram_addr  = bus_act ? {addr_p0[ADDR_W-1:2], 2'b00} : '0;
  assign bus.ram_wdata = bus_act ? wdata_p0 : 32'h0;

endmodule
